// File: rtl/time_display_scanner.sv
// Samples the time fields once per frame, converts each to two BCD digits with a
// sequential shift-add-3 converter and scans the eight digits onto a 7-segment display.
module time_display_scanner #(
  parameter int DIGIT_CYCLES = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clockSignal,
  input  logic       startOrStop,
  input  logic [4:0] hoursIn,
  input  logic [5:0] minutesIn,
  input  logic [5:0] secondsIn,
  input  logic [6:0] centisIn,
  input  logic       ringIn,
  output logic [7:0] anodeSelect,
  output logic [6:0] segmentOut,
  output logic       decimalPoint,
  output logic       frameStart
);

  // state | meaning
  // IDLE  | nothing converted since reset; commit loads a blank buffer
  // CONV  | shifting the four fields, 7 cycles each, in order H, M, S, c
  // DONE  | results held until the next frame start commits them
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [3:0] BLANK = 4'hF;

  conv_state_t state_q, state_d;

  logic [2:0]    digit_idx;
  logic [SW-1:0] sub_cnt;
  logic          frame_start;
  logic          last_sub;

  logic [6:0]  min_q, sec_q, cen_q;
  logic [18:0] sr_q;
  logic [2:0]  bit_cnt;
  logic [1:0]  field_idx;
  logic [3:0]  res_q  [8];
  logic [3:0]  disp_q [8];
  logic        blink_q, frame_dark_q;

  logic [18:0] sr_adj, sr_shift;
  logic        sat;
  logic [3:0]  tens_d, ones_d;
  logic [6:0]  next_field;
  logic [3:0]  digit_now;
  logic        dark_now, lit;
  logic [7:0]  anode_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign frame_start = (digit_idx == 3'd7) && (sub_cnt == '0);
  assign last_sub    = (sub_cnt == SW'(DIGIT_CYCLES - 1));

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      digit_idx <= 3'd7;
      sub_cnt   <= '0;
    end else if (last_sub) begin
      sub_cnt   <= '0;
      digit_idx <= digit_idx - 3'd1;
    end else begin
      sub_cnt   <= sub_cnt + SW'(1);
    end
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = CONV;
    end else begin
      case (state_q)
        CONV:    if (field_idx == 2'd3 && bit_cnt == 3'd0) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // One add-3 adjust plus one shift per cycle; a hundreds digit means the field was >99.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_adj[7+4*i +: 4] >= 4'd5) sr_adj[7+4*i +: 4] = sr_adj[7+4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[17:0], 1'b0};
    sat      = (sr_shift[18:15] != 4'd0);
    tens_d   = sat ? 4'd9 : sr_shift[14:11];
    ones_d   = sat ? 4'd9 : sr_shift[10:7];
    case (field_idx)
      2'd0:    next_field = min_q;
      2'd1:    next_field = sec_q;
      default: next_field = cen_q;
    endcase
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      min_q     <= '0;
      sec_q     <= '0;
      cen_q     <= '0;
      sr_q      <= '0;
      bit_cnt   <= '0;
      field_idx <= '0;
      for (int i = 0; i < 8; i++) res_q[i] <= BLANK;
    end else if (frame_start) begin
      min_q     <= {1'b0, minutesIn};
      sec_q     <= {1'b0, secondsIn};
      cen_q     <= centisIn;
      sr_q      <= {14'd0, hoursIn};
      bit_cnt   <= 3'd6;
      field_idx <= 2'd0;
    end else if (state_q == CONV) begin
      if (bit_cnt == 3'd0) begin
        res_q[{~field_idx, 1'b1}] <= tens_d;
        res_q[{~field_idx, 1'b0}] <= ones_d;
        sr_q      <= {12'd0, next_field};
        bit_cnt   <= 3'd6;
        field_idx <= field_idx + 2'd1;
      end else begin
        sr_q    <= sr_shift;
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      for (int i = 0; i < 8; i++) disp_q[i] <= BLANK;
      blink_q      <= 1'b0;
      frame_dark_q <= 1'b0;
    end else if (frame_start) begin
      for (int i = 0; i < 8; i++) disp_q[i] <= (state_q == DONE) ? res_q[i] : BLANK;
      blink_q      <= ringIn ? ~blink_q : 1'b0;
      frame_dark_q <= ringIn & blink_q;
    end
  end

  // The commit edge already drives the new frame's first digit, so bypass the buffer there.
  always_comb begin
    if (frame_start) begin
      digit_now = (state_q == DONE) ? res_q[digit_idx] : BLANK;
      dark_now  = ringIn & blink_q;
    end else begin
      digit_now = disp_q[digit_idx];
      dark_now  = frame_dark_q;
    end
    lit     = !dark_now && (digit_now != BLANK);
    anode_d = lit ? (8'd1 << digit_idx) : 8'd0;
    seg_d   = lit ? seg_decode(digit_now) : 7'd0;
    dp_d    = lit && (digit_idx == 3'd6 || digit_idx == 3'd4 || digit_idx == 3'd2);
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      anodeSelect  <= {8{ACTIVE_LOW}};
      segmentOut   <= {7{ACTIVE_LOW}};
      decimalPoint <= ACTIVE_LOW;
      frameStart   <= 1'b0;
    end else begin
      anodeSelect  <= anode_d ^ {8{ACTIVE_LOW}};
      segmentOut   <= seg_d ^ {7{ACTIVE_LOW}};
      decimalPoint <= dp_d ^ ACTIVE_LOW;
      frameStart   <= frame_start;
    end
  end

endmodule

// File: tb/tb_time_display_scanner.sv
// Drives both output polarities of time_display_scanner from shared stimulus and
// compares every cycle against a frame-level model built from the display rules.
module tb_time_display_scanner;

  localparam int FRAME = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] centis;
  logic       ring;

  logic [7:0] an_h, an_l;
  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l, fs_h, fs_l;

  int n_vec = 0;
  int n_bad = 0;

  time_display_scanner #(.DIGIT_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clockSignal(clk), .startOrStop(rst), .hoursIn(hours), .minutesIn(minutes),
    .secondsIn(seconds), .centisIn(centis), .ringIn(ring), .anodeSelect(an_h),
    .segmentOut(seg_h), .decimalPoint(dp_h), .frameStart(fs_h));

  time_display_scanner #(.DIGIT_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clockSignal(clk), .startOrStop(rst), .hoursIn(hours), .minutesIn(minutes),
    .secondsIn(seconds), .centisIn(centis), .ringIn(ring), .anodeSelect(an_l),
    .segmentOut(seg_l), .decimalPoint(dp_l), .frameStart(fs_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", tag, $time, got, exp);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [3:0] tens_of(input int v);
    return (v > 99) ? 4'd9 : 4'(v / 10);
  endfunction
  function automatic logic [3:0] ones_of(input int v);
    return (v > 99) ? 4'd9 : 4'(v % 10);
  endfunction

  // Model state: cycles since reset release, digits shown now and digits captured for next frame.
  int         t;
  int         ring_run;
  bit         cur_valid, nxt_valid, cur_dark;
  logic [3:0] cur_dig [8];
  logic [3:0] nxt_dig [8];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fs;

  task automatic model_step();
    int pos, d;
    bit lit;
    if (rst) begin
      t = 0; ring_run = 0; cur_valid = 0; nxt_valid = 0; cur_dark = 0;
      return;
    end
    pos = t % FRAME;
    if (pos == 0) begin
      cur_valid = nxt_valid;
      cur_dig   = nxt_dig;
      nxt_dig[7] = tens_of(int'(hours));   nxt_dig[6] = ones_of(int'(hours));
      nxt_dig[5] = tens_of(int'(minutes)); nxt_dig[4] = ones_of(int'(minutes));
      nxt_dig[3] = tens_of(int'(seconds)); nxt_dig[2] = ones_of(int'(seconds));
      nxt_dig[1] = tens_of(int'(centis));  nxt_dig[0] = ones_of(int'(centis));
      nxt_valid = 1;
      ring_run  = ring ? ring_run + 1 : 0;
      cur_dark  = ring && (ring_run % 2 == 0);
    end
    d       = 7 - pos / 4;
    lit     = cur_valid && !cur_dark;
    exp_an  = lit ? (8'd1 << d) : 8'd0;
    exp_seg = lit ? seg_tab[cur_dig[d]] : 7'd0;
    exp_dp  = lit && (d == 6 || d == 4 || d == 2);
    exp_fs  = (pos == 0);
    t++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic check_inactive(input string tag);
    chk({tag, "_an_h"}, an_h, 8'h00);
    chk({tag, "_an_l"}, an_l, 8'hFF);
    chk({tag, "_seg_h"}, {1'b0, seg_h}, 8'h00);
    chk({tag, "_seg_l"}, {1'b0, seg_l}, 8'h7F);
    chk({tag, "_dp_l"}, {7'd0, dp_l}, 8'h01);
    chk({tag, "_fs"}, {6'd0, fs_h, fs_l}, 8'h00);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check_inactive("rst");
      end else if (t > 0) begin
        chk("an_h", an_h, exp_an);
        chk("an_l", an_l, ~exp_an);
        chk("seg_h", {1'b0, seg_h}, {1'b0, exp_seg});
        chk("seg_l", {1'b0, seg_l}, {1'b0, ~exp_seg});
        chk("dp", {6'd0, dp_h, dp_l}, {6'd0, exp_dp, ~exp_dp});
        chk("fs", {6'd0, fs_h, fs_l}, {6'd0, exp_fs, exp_fs});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b1; ring = 1'b0;
    hours = 5'd13; minutes = 6'd5; seconds = 6'd59; centis = 7'd7;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(3 * FRAME);

    hours = 5'd31; centis = 7'd127;
    wait_cycles(2 * FRAME);

    seconds = 6'd10;
    wait_cycles(2 * FRAME + 16);
    seconds = 6'd20;
    wait_cycles(3 * FRAME);

    ring = 1'b1;
    wait_cycles(4 * FRAME);
    ring = 1'b0;
    wait_cycles(2 * FRAME);

    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hours   = 5'($urandom_range(0, 31));
        minutes = 6'($urandom_range(0, 63));
        seconds = 6'($urandom_range(0, 63));
        centis  = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 31) == 0) ring = ~ring;
      wait_cycles(1);
    end
    ring = 1'b0;
    wait_cycles(2 * FRAME);

    begin
      bit hit = 0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
        wait_cycles(1);
        if (t % FRAME == 15) hit = 1;
      end
      if (!hit) begin
        n_vec++; n_bad++;
        $display("FAIL midconv_sync: cycle 15 not reached within %0d cycles", 2 * FRAME);
      end
    end
    hours = 5'd9; minutes = 6'd42; seconds = 6'd3; centis = 7'd88;
    rst = 1'b1;
    #1;
    check_inactive("async");
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
